// File: rtl/pps_dmem_sram_ctrl.sv
// Data-memory SRAM controller: registered strobes, RD/WR wait-state FSM.
// Optional DMEM_BWE_CHECK_EN skips stores with illegal byte-enable patterns.
module pps_dmem_sram_ctrl #(
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_memop_in,
  input  logic        MEM_memwr_in,
  input  logic [31:0] MEM_Addr_in,
  input  logic [3:0]  MEM_bwe_in,
  input  logic [31:0] MEM_STData_in,
  output logic [31:0] MEM_LDData_out,
  output logic        MEM_stall_out,
  output logic        MEM_err_out,
  output logic [17:0] sram_addr,
  output logic [31:0] sram_dq_o,
  input  logic [31:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n
);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [17:0] addr_q, addr_d;
  logic [31:0] dq_o_q, dq_o_d;
  logic [3:0]  bwe_q, bwe_d;
  logic [31:0] ld_q, ld_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic [3:0]  be_n_q, be_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic        unused_addr_bits;

`ifdef DMEM_BWE_CHECK_EN
  logic err_q, err_d;
  logic bwe_legal;

  always_comb begin
    unique case (MEM_bwe_in)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100,
      4'b1000: bwe_legal = 1'b1;
      default: bwe_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign MEM_err_out = err_q;
`else
  assign MEM_err_out = 1'b0;
`endif

  assign unused_addr_bits = ^{MEM_Addr_in[31:20], MEM_Addr_in[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;
    bwe_d   = bwe_q;
    ld_d    = ld_q;
`ifdef DMEM_BWE_CHECK_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (MEM_memop_in) begin
          addr_d = MEM_Addr_in[19:2];
          bwe_d  = MEM_bwe_in;
          cnt_d  = 4'd0;
          if (MEM_memwr_in) begin
            dq_o_d  = MEM_STData_in;
            state_d = WR_SETUP;
`ifdef DMEM_BWE_CHECK_EN
            if (!bwe_legal) begin
              state_d = DONE;
              err_d   = 1'b1;
            end
`endif
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q == 4'(RD_WAIT - 1)) begin
          ld_d    = sram_dq_i;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_SETUP: begin
        cnt_d   = 4'd0;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q == 4'(WR_WAIT - 1)) state_d = WR_HOLD;
        else                          cnt_d = cnt_q + 4'd1;
      end
      WR_HOLD: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so the pins are pure flops.
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = 4'hf;
    dq_oe_d = 1'b0;
    unique case (state_d)
      RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = 4'h0;
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_d  = 1'b0;
        be_n_d  = ~bwe_d;
        dq_oe_d = 1'b1;
      end
      WR_PULSE: begin
        ce_n_d  = 1'b0;
        be_n_d  = ~bwe_d;
        dq_oe_d = 1'b1;
        we_n_d  = (bwe_d == 4'h0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 18'd0;
      dq_o_q  <= 32'd0;
      bwe_q   <= 4'd0;
      ld_q    <= 32'd0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 4'hf;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      bwe_q   <= bwe_d;
      ld_q    <= ld_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign MEM_stall_out  = (state_q == IDLE && MEM_memop_in) ||
                          state_q == RD || state_q == WR_SETUP ||
                          state_q == WR_PULSE || state_q == WR_HOLD;
  assign MEM_LDData_out = ld_q;
  assign sram_addr      = addr_q;
  assign sram_dq_o      = dq_o_q;
  assign sram_dq_oe     = dq_oe_q;
  assign sram_ce_n      = ce_n_q;
  assign sram_oe_n      = oe_n_q;
  assign sram_we_n      = we_n_q;
  assign sram_be_n      = be_n_q;

endmodule

// File: tb/tb_pps_dmem_sram_ctrl.sv
// Bench for pps_dmem_sram_ctrl: behavioural SRAM, load-data scoreboard,
// per-access timing and strobe checks.
module tb_pps_dmem_sram_ctrl;

  localparam int RDW = 1;
  localparam int WRW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memop, memwr;
  logic [31:0] addr_in, st_data;
  logic [3:0]  bwe_in;
  logic [31:0] ld_out;
  logic        stall, err;
  logic [17:0] sram_addr;
  logic [31:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  logic [31:0] smem [64];
  logic [31:0] exp_mem [64];
  logic [31:0] exp_q [$];
  logic [31:0] last_ld;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pps_dmem_sram_ctrl #(.RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_memop_in(memop), .MEM_memwr_in(memwr),
    .MEM_Addr_in(addr_in), .MEM_bwe_in(bwe_in),
    .MEM_STData_in(st_data), .MEM_LDData_out(ld_out),
    .MEM_stall_out(stall), .MEM_err_out(err),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  assign sram_dq_i = smem[sram_addr[5:0]];

  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b])
          smem[sram_addr[5:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit bwe_skip(logic [3:0] b);
`ifdef DMEM_BWE_CHECK_EN
    return !(b inside {4'b1111, 4'b0011, 4'b1100, 4'b0001,
                       4'b0010, 4'b0100, 4'b1000});
`else
    return (b !== b);
`endif
  endfunction

  task automatic access(bit wr, logic [31:0] a, logic [3:0] bwe,
                        logic [31:0] data, bit last, string tag);
    int done_c, wlow, olow, ovl, exp_done, exp_wlow, exp_olow, idx;
    logic [3:0]  be_seen, nbwe;
    logic [31:0] dq_seen, ld_exp;
    logic [17:0] a_seen;
    logic        err_seen;
    bit          skip;
    skip = wr && bwe_skip(bwe);
    idx  = int'(a[7:2]);
    nbwe = ~bwe;
    done_c = -1; wlow = 0; olow = 0; ovl = 0;
    err_seen = 1'b0; a_seen = '0; be_seen = '0; dq_seen = '0;
    @(posedge clk); #1;
    memop = 1'b1; memwr = wr; addr_in = a;
    bwe_in = bwe; st_data = data;
    if (!wr) exp_q.push_back(exp_mem[idx]);
    else if (!skip)
      for (int b = 0; b < 4; b++)
        if (bwe[b]) exp_mem[idx][8*b +: 8] = data[8*b +: 8];
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!sram_we_n) begin
        wlow++; be_seen = sram_be_n; dq_seen = sram_dq_o;
      end
      if (!sram_oe_n) olow++;
      if (sram_dq_oe && !sram_oe_n) ovl++;
      if (!stall) begin
        done_c = c; err_seen = err; a_seen = sram_addr;
        break;
      end
    end
    if (last) memop = 1'b0;
    exp_done = skip ? 1 : (wr ? WRW + 3 : RDW + 1);
    exp_wlow = (wr && !skip && bwe != 4'h0) ? WRW : 0;
    exp_olow = wr ? 0 : RDW;
    chk({tag, ".done_cycle"}, done_c, exp_done);
    chk({tag, ".we_low_cycles"}, wlow, exp_wlow);
    chk({tag, ".oe_low_cycles"}, olow, exp_olow);
    chk({tag, ".oe_dq_overlap"}, ovl, 0);
    chk({tag, ".err"}, 32'(err_seen), 32'(skip));
    chk({tag, ".sram_addr"}, 32'(a_seen), 32'(a[19:2]));
    if (wlow > 0) begin
      chk({tag, ".be_n"}, 32'(be_seen), 32'(nbwe));
      chk({tag, ".dq_o"}, dq_seen, data);
    end
    if (!wr) begin
      ld_exp = exp_q.pop_front();
      chk({tag, ".ld_data"}, ld_out, ld_exp);
      last_ld = ld_exp;
    end else begin
      chk({tag, ".ld_hold"}, ld_out, last_ld);
    end
  endtask

  initial begin
    int wl;
    for (int i = 0; i < 64; i++) begin
      smem[i] = '0; exp_mem[i] = '0;
    end
    smem[1] = 32'hDEADBEEF; exp_mem[1] = 32'hDEADBEEF;
    last_ld = '0;
    rst_n = 1'b0; memop = 1'b0; memwr = 1'b0;
    addr_in = '0; bwe_in = '0; st_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ce_n", 32'(sram_ce_n), 1);
    chk("rst.oe_n", 32'(sram_oe_n), 1);
    chk("rst.we_n", 32'(sram_we_n), 1);
    chk("rst.be_n", 32'(sram_be_n), 32'hf);
    chk("rst.dq_oe", 32'(sram_dq_oe), 0);
    chk("rst.addr", 32'(sram_addr), 0);
    chk("rst.dq_o", sram_dq_o, 0);
    chk("rst.ld", ld_out, 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.stall", 32'(stall), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    access(0, 32'h0000_0104, 4'h0, 32'h0, 1, "ld104");
    access(1, 32'h0000_0010, 4'b1100, 32'h12345678, 1, "st10");
    access(0, 32'h0000_0010, 4'h0, 32'h0, 0, "b2b_ld10");
    access(1, 32'h0000_0020, 4'b1111, 32'hA5A5A5A5, 0, "b2b_st20");
    access(0, 32'h0000_0020, 4'h0, 32'h0, 1, "b2b_ld20");
    access(1, 32'h0000_0010, 4'b0000, 32'hFFFFFFFF, 1, "st_bwe0");
    access(0, 32'h0000_0010, 4'h0, 32'h0, 1, "ld10_again");
    access(1, 32'h0000_0024, 4'b0101, 32'h11223344, 1, "st_bwe0101");
    access(0, 32'h0000_0024, 4'h0, 32'h0, 1, "ld24");

    // Reset in the middle of the write pulse.
    @(posedge clk); #1;
    memop = 1'b1; memwr = 1'b1; addr_in = 32'h30;
    bwe_in = 4'hf; st_data = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    chk("rstmid.we_low_before", 32'(sram_we_n), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstmid.we_n", 32'(sram_we_n), 1);
    chk("rstmid.dq_oe", 32'(sram_dq_oe), 0);
    chk("rstmid.ce_n", 32'(sram_ce_n), 1);
    chk("rstmid.be_n", 32'(sram_be_n), 32'hf);
    chk("rstmid.addr", 32'(sram_addr), 0);
    chk("rstmid.ld", ld_out, 0);
    chk("rstmid.stall_eq_memop", 32'(stall), 32'(memop));
    memop = 1'b0; rst_n = 1'b1;
    #1 chk("rstmid.idle_stall", 32'(stall), 0);
    last_ld = '0;
    wl = 0;
    repeat (8) begin
      @(negedge clk);
      if (!sram_we_n) wl++;
    end
    chk("rstmid.no_retry", wl, 0);
    access(0, 32'h0000_0104, 4'h0, 32'h0, 1, "post_rst_ld");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
